// File: rtl/zprize_mul_issue_collect_if.sv
// Handshake bundle between the issue/collect block, its requester,
// the fixed-latency multiplier and the result consumer.
interface zprize_mul_issue_collect_if #(
  parameter int W0 = 384,
  parameter int W1 = 384,
  parameter int M  = 32
);
  logic                 req_valid;
  logic                 req_ready;
  logic [W0-1:0]        req_a;
  logic [W1-1:0]        req_b;
  logic [M-1:0]         req_tag;
  logic [W0-1:0]        mul_in0;
  logic [W1-1:0]        mul_in1;
  logic [M:0]           mul_m_i;
  logic [W0+W1-1:0]     mul_out;
  logic [M:0]           mul_m_o;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [W0+W1-1:0]     rsp_prod;
  logic [M-1:0]         rsp_tag;

  // Environment side: requester, multiplier and consumer.
  modport master (
    output req_valid, req_a, req_b, req_tag, mul_out, mul_m_o, rsp_ready,
    input  req_ready, mul_in0, mul_in1, mul_m_i, rsp_valid, rsp_prod, rsp_tag
  );

  // Issue/collect block side.
  modport slave (
    input  req_valid, req_a, req_b, req_tag, mul_out, mul_m_o, rsp_ready,
    output req_ready, mul_in0, mul_in1, mul_m_i, rsp_valid, rsp_prod, rsp_tag
  );
endinterface

// File: rtl/zprize_mul_issue_collect.sv
// Issues operand pairs into a fixed-latency, non-stalling multiplier and
// collects tagged products into an in-order result FIFO. A credit is taken
// per issue so a returning product always has a FIFO slot waiting.
//
// state | meaning
// FLUSH | after reset: stale metadata valids drain from the multiplier, no issue/capture
// RUN   | normal operation: issue while credit remains, capture tagged products
module zprize_mul_issue_collect #(
  parameter int W0  = 384,
  parameter int W1  = 384,
  parameter int M   = 32,
  parameter int LAT = 5,
  parameter int FD  = 8
) (
  input  logic clk,
  input  logic rst,
  output logic busy,
  zprize_mul_issue_collect_if.slave bus
);
  localparam int AW = $clog2(FD);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(LAT + 1);
  localparam int DW = W0 + W1 + M;

  typedef enum logic {FLUSH = 1'b0, RUN = 1'b1} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] flush_cnt;
  logic [PW-1:0] credit;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [DW-1:0] mem [FD];
  logic          req_ready;
  logic          cap_en;
  logic          issue;
  logic          pop;
  logic          empty;
  logic          full;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= FLUSH;
    else      state <= state_nxt;
  end

  // Flush timer: counts the multiplier depth down so every stale valid has left the pipe.
  always_ff @(posedge clk) begin
    if (!rst)                                   flush_cnt <= CW'(LAT);
    else if (state == FLUSH && flush_cnt != '0) flush_cnt <= flush_cnt - CW'(1);
  end

  // Next state: leave FLUSH on the edge where the timer reaches zero.
  always_comb begin
    state_nxt = state;
    if (state == FLUSH && flush_cnt <= CW'(1)) state_nxt = RUN;
  end

  // State-decoded outputs; ready is held low while reset is asserted.
  always_comb begin
    req_ready = 1'b0;
    cap_en    = 1'b0;
    if (state == RUN) begin
      req_ready = rst && (credit != '0);
      cap_en    = bus.mul_m_o[M];
    end
  end

  assign issue         = bus.req_valid & req_ready;
  assign pop           = bus.rsp_valid & bus.rsp_ready;
  assign bus.req_ready = req_ready;
  assign bus.mul_in0   = issue ? bus.req_a : '0;
  assign bus.mul_in1   = issue ? bus.req_b : '0;
  assign bus.mul_m_i   = {issue, issue ? bus.req_tag : '0};

  // Credit: a pop frees its slot only from the next cycle on.
  always_ff @(posedge clk) begin
    if (!rst)                credit <= PW'(FD);
    else if (issue && !pop)  credit <= credit - PW'(1);
    else if (pop && !issue)  credit <= credit + PW'(1);
  end

  // FIFO pointers, one extra bit to tell full from empty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (cap_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)    rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // FIFO storage; contents are meaningless until the pointers say otherwise.
  always_ff @(posedge clk) begin
    if (cap_en) mem[wr_ptr[AW-1:0]] <= {bus.mul_out, bus.mul_m_o[M-1:0]};
  end

  assign empty                     = (wr_ptr == rd_ptr);
  assign full                      = (wr_ptr[AW] != rd_ptr[AW]) &&
                                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign bus.rsp_valid             = rst & ~empty;
  assign {bus.rsp_prod, bus.rsp_tag} = mem[rd_ptr[AW-1:0]];
  assign busy                      = (state == FLUSH) | (credit != PW'(FD));

  // Credits make a capture into a full FIFO impossible.
  a_no_write_full: assert property (@(posedge clk) disable iff (!rst) !(cap_en && full));
endmodule

// File: tb/tb_zprize_mul_issue_collect.sv
// Bench for zprize_mul_issue_collect: a non-resetting multiplier model, a
// queue-based reference of accepted requests, and directed scenarios.
module tb_zprize_mul_issue_collect;
  localparam int W0  = 384;
  localparam int W1  = 384;
  localparam int M   = 32;
  localparam int LAT = 5;
  localparam int FD  = 8;
  localparam int PWD = W0 + W1;

  typedef logic [PWD-1:0] w_t;
  typedef struct {
    logic [PWD-1:0] p;
    logic [M-1:0]   tag;
    int unsigned    t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inj = 1'b0;
  logic        busy;
  int          n_chk = 0;
  int          n_fail = 0;
  int unsigned tcyc = 0;

  zprize_mul_issue_collect_if #(.W0(W0), .W1(W1), .M(M)) bus ();

  zprize_mul_issue_collect #(.W0(W0), .W1(W1), .M(M), .LAT(LAT), .FD(FD)) dut (
    .clk  (clk),
    .rst  (rst),
    .busy (busy),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Cycle counter, stable when read at the falling edge.
  always @(posedge clk) tcyc <= tcyc + 1;

  // Multiplier: LAT-deep pipe, metadata never reset.
  logic [PWD-1:0] pp [LAT];
  logic [M:0]     pm [LAT];
  always @(posedge clk) begin
    pp[0] <= PWD'(bus.mul_in0) * PWD'(bus.mul_in1);
    pm[0] <= bus.mul_m_i;
    for (int i = 1; i < LAT; i++) begin
      pp[i] <= pp[i-1];
      pm[i] <= pm[i-1];
    end
  end
  assign bus.mul_out = pp[LAT-1];
  assign bus.mul_m_o = inj ? {1'b1, M'(32'h0BAD)} : pm[LAT-1];

  task automatic chk(input string nm, input w_t act, input w_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, tcyc);
    end
  endtask

  // Reference model: queue of accepted requests with the cycle their result becomes visible.
  exp_t q[$];
  int   flush_left = LAT;
  bit   chk_en = 1'b0;
  always @(negedge clk) begin
    bit run, er, ev, iss;
    run = (flush_left == 0);
    er  = rst && run && (q.size() < FD);
    ev  = rst && (q.size() != 0) && (q[0].t <= tcyc);
    iss = bus.req_valid && er;
    if (chk_en) begin
      chk("m_req_ready", w_t'(bus.req_ready), w_t'(er));
      chk("m_rsp_valid", w_t'(bus.rsp_valid), w_t'(ev));
      if (ev) begin
        chk("m_rsp_prod", bus.rsp_prod, q[0].p);
        chk("m_rsp_tag", w_t'(bus.rsp_tag), w_t'(q[0].tag));
      end
      chk("m_mul_m_i", w_t'(bus.mul_m_i), w_t'(iss ? {1'b1, bus.req_tag} : {(M+1){1'b0}}));
      chk("m_mul_in0", w_t'(bus.mul_in0), w_t'(iss ? bus.req_a : {W0{1'b0}}));
      if (rst) chk("m_busy", w_t'(busy), w_t'(!run || q.size() != 0));
    end
    if (!rst) begin
      q.delete();
      flush_left = LAT;
      chk_en     = 1'b1;
    end else begin
      if (ev && bus.rsp_ready) void'(q.pop_front());
      if (iss) q.push_back('{p: PWD'(bus.req_a) * PWD'(bus.req_b), tag: bus.req_tag,
                             t: tcyc + LAT + 1});
      if (flush_left > 0) flush_left--;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Directed scenarios with literal expectations.
  initial begin
    int zeros, acc, got, drops, stale, i;
    bit pend;
    int unsigned t0;
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_tag   = '0;
    bus.rsp_ready = 1'b1;
    rst = 1'b0;
    inj = 1'b1;
    repeat (3) step();
    rst = 1'b1;

    // Flush length, with a forced metadata valid throughout FLUSH.
    zeros = 0;
    for (int k = 0; k < 12; k++) begin
      at_neg();
      if (bus.req_ready) break;
      zeros++;
      step();
      if (zeros >= LAT) inj = 1'b0;
    end
    inj = 1'b0;
    chk("flush_len", w_t'(zeros), w_t'(5));
    chk("ready_after_flush", w_t'(bus.req_ready), w_t'(1));
    chk("no_capture_in_flush", w_t'(bus.rsp_valid), w_t'(0));
    step();

    // Single op.
    bus.req_a = W0'(3); bus.req_b = W1'(5); bus.req_tag = M'(32'h11); bus.req_valid = 1'b1;
    at_neg();
    t0 = tcyc;
    chk("single_accept", w_t'(bus.req_ready), w_t'(1));
    step();
    bus.req_valid = 1'b0;
    got = -1;
    for (int k = 0; k < 20; k++) begin
      at_neg();
      if (bus.rsp_valid) begin
        got = int'(tcyc - t0);
        chk("single_prod", bus.rsp_prod, w_t'(15));
        chk("single_tag", w_t'(bus.rsp_tag), w_t'(32'h11));
        break;
      end
      step();
    end
    chk("single_latency", w_t'(got), w_t'(6));
    step();

    // Backpressure: fill with rsp_ready low, then drain.
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_b = W1'(2);
    acc = 0;
    bus.req_a = W0'(acc); bus.req_tag = M'(acc);
    for (int k = 0; k < 20; k++) begin
      at_neg();
      if (bus.req_ready) acc++;
      step();
      bus.req_a = W0'(acc); bus.req_tag = M'(acc);
    end
    at_neg();
    chk("bp_accepted", w_t'(acc), w_t'(8));
    chk("bp_ready_low", w_t'(bus.req_ready), w_t'(0));
    step();
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    got = 0;
    pend = 1'b0;
    for (int k = 0; k < 30 && got < 8; k++) begin
      at_neg();
      if (pend) begin
        chk("bp_ready_after_pop", w_t'(bus.req_ready), w_t'(1));
        pend = 1'b0;
      end
      if (bus.rsp_valid) begin
        if (got == 0) begin
          chk("bp_ready_at_pop", w_t'(bus.req_ready), w_t'(0));
          pend = 1'b1;
        end
        chk("bp_tag", w_t'(bus.rsp_tag), w_t'(got));
        chk("bp_prod", bus.rsp_prod, w_t'(2 * got));
        got++;
      end
      step();
    end
    chk("bp_count", w_t'(got), w_t'(8));

    // Throughput: 100 back-to-back requests with a free-running consumer.
    i = 0; got = 0; drops = 0;
    fork
      begin
        for (int k = 0; k < 200 && i < 100; k++) begin
          bus.req_valid = 1'b1;
          bus.req_a = W0'(i); bus.req_b = W1'(i + 1); bus.req_tag = M'(i);
          at_neg();
          if (bus.req_ready) i++;
          else drops++;
          step();
        end
        bus.req_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 300 && got < 100; k++) begin
          at_neg();
          if (bus.rsp_valid) begin
            chk("tp_prod", bus.rsp_prod, w_t'(got * (got + 1)));
            chk("tp_tag", w_t'(bus.rsp_tag), w_t'(got));
            got++;
          end
          @(posedge clk);
        end
      end
    join
    chk("tp_drops", w_t'(drops), w_t'(0));
    chk("tp_results", w_t'(got), w_t'(100));
    step();

    // Credit-0 boundary: pop and request together at zero credit.
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_b = W1'(3);
    acc = 0;
    bus.req_a = W0'(acc); bus.req_tag = M'(acc + 64);
    for (int k = 0; k < 30; k++) begin
      at_neg();
      if (bus.req_ready) acc++;
      step();
      bus.req_a = W0'(acc); bus.req_tag = M'(acc + 64);
    end
    bus.rsp_ready = 1'b1;
    at_neg();
    chk("c0_pop_valid", w_t'(bus.rsp_valid), w_t'(1));
    chk("c0_no_issue", w_t'(bus.req_ready), w_t'(0));
    step();
    bus.rsp_ready = 1'b0;
    at_neg();
    chk("c0_issue_next", w_t'(bus.req_ready), w_t'(1));
    step();
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      at_neg();
      if (!busy) break;
      step();
    end
    chk("c0_drained", w_t'(busy), w_t'(0));
    step();

    // Reset mid-flight: 2 queued, 3 in the multiplier.
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_a = W0'(7); bus.req_b = W1'(7);
    for (int k = 0; k < 2; k++) begin
      bus.req_tag = M'(160 + k);
      at_neg();
      step();
    end
    bus.req_valid = 1'b0;
    repeat (LAT + 1) step();
    at_neg();
    chk("mf_queued", w_t'(bus.rsp_valid), w_t'(1));
    step();
    bus.req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.req_tag = M'(162 + k);
      at_neg();
      step();
    end
    bus.req_valid = 1'b0;
    rst = 1'b0;
    at_neg();
    chk("mf_valid_in_reset", w_t'(bus.rsp_valid), w_t'(0));
    step();
    rst = 1'b1;
    bus.rsp_ready = 1'b1;
    at_neg();
    chk("mf_valid_after_edge", w_t'(bus.rsp_valid), w_t'(0));
    stale = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      at_neg();
      if (bus.rsp_valid) stale++;
    end
    chk("mf_no_stale", w_t'(stale), w_t'(0));
    chk("mf_credit_full", w_t'(busy), w_t'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #1000000;
    $display("FAIL watchdog: run time limit reached, got no end of test, expected end of test");
    $fatal(1, "time limit");
  end
endmodule
